// File: rtl/hex_scan_driver_pkg.sv
// Shared constants for the 4-digit hex scan driver: digit count and
// active-low anode enable patterns.
package hex_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] an_pattern(input digit_t d);
        case (d)
            2'd0:    an_pattern = AN_D0;
            2'd1:    an_pattern = AN_D1;
            2'd2:    an_pattern = AN_D2;
            2'd3:    an_pattern = AN_D3;
            default: an_pattern = AN_OFF;
        endcase
    endfunction

    function automatic logic [3:0] nibble_of(input logic [15:0] v, input digit_t d);
        case (d)
            2'd0:    nibble_of = v[3:0];
            2'd1:    nibble_of = v[7:4];
            2'd2:    nibble_of = v[11:8];
            default: nibble_of = v[15:12];
        endcase
    endfunction

endpackage

// File: rtl/hex_scan_driver_scan_prescaler.sv
// Slot-rate prescaler: counts 0..DIV-1 and flags the last cycle of each slot.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign slot_end = (count == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (slot_end) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with frame-synchronous
// double-buffered updates. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        ready,
    output logic [0:3]  hex,
    output logic [3:0]  an,
    output logic [1:0]  digit,
    output logic        frame_tick
);

    logic        slot_end;
    logic        wrap;
    logic        commit;
    logic        blank;
    digit_t      digit_next;
    logic [15:0] shown;
    logic [15:0] shown_next;
    logic [15:0] pend;
    logic        pending;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end)
    );

    assign wrap   = slot_end && (digit == 2'd3);
    assign commit = wrap && pending;
    assign ready  = ~pending;

    // Outputs are computed from next-state digit/shown so the registered
    // hex/an line up with the registered digit index.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        digit_next = digit;
        shown_next = shown;
        blank      = 1'b0;
        if (slot_end) begin
            digit_next = digit + 2'd1;
        end
        if (commit) begin
            shown_next = pend;
        end
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_next)
            2'd3:    blank = (shown_next[15:12] == 4'h0);
            2'd2:    blank = (shown_next[15:8]  == 8'h00);
            2'd1:    blank = (shown_next[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
    end

    // NOTE: the display buffers are ordinary registers, so they are reset
    // explicitly; a mid-frame reset must discard any pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit      <= '0;
            shown      <= '0;
            pend       <= '0;
            pending    <= 1'b0;
            hex        <= 4'h0;
            an         <= AN_D0;
            frame_tick <= 1'b0;
        end else begin
            digit      <= digit_next;
            shown      <= shown_next;
            frame_tick <= wrap;
            hex        <= nibble_of(shown_next, digit_next);
            an         <= blank ? AN_OFF : an_pattern(digit_next);
            // A load on the commit cycle refills pend and keeps pending set.
            if (load) begin
                pend    <= value;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. Holds a 16-bit display value, walks the four digits in turn, and on each slot drives one nibble into the downstream hex-to-7-segment decoder plus the matching active-low anode enable. Value updates are double-buffered and committed only at frame boundaries, so a digit never shows a half-updated value.

## Interface
- DIV, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range DIV >= 2.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures value into the pending buffer.
- value  in  16  display value; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- ready  out  1  high when no update is pending.
- hex  out  [0:3]  nibble for the decoder; hex[0] is the nibble MSB.
- an  out  4  active-low anode enables; an[i] low selects digit i.
- digit  out  2  index of the digit currently driven.
- frame_tick  out  1  one-cycle pulse on the cycle the scan wraps from digit 3 to digit 0.

## Operation
- Prescaler counts 0..DIV-1 and wraps; slot_end = (count == DIV-1).
- On slot_end: digit <= digit + 1, mod 4.
- Registers: shown[15:0], the displayed value; pend[15:0] plus a pending flag.
- load: pend <= value, pending <= 1. A load while pending is already set overwrites pend; the last load wins.
- Commit: on slot_end with digit == 3 and pending == 1, shown <= pend and pending <= 0. frame_tick pulses on this cycle whether or not a commit occurs.
- load on the commit cycle: shown takes the old pend; the new value goes into pend; pending stays 1.
- ready = ~pending.
- hex = shown nibble selected by the next-state digit.
- an = one-hot-low of digit, unless the digit is blanked.
- hex, an, digit and frame_tick are registered outputs, with no combinational path from load/value to them.
- No arithmetic beyond the prescaler increment and the 2-bit digit increment. The digit counter wraps naturally; the prescaler width is clog2(DIV).

## Timing
- Reset values:
  - count = 0, digit = 0, shown = 0, pend = 0, pending = 0
  - ready = 1, hex = 4'h0, an = 4'b1110, frame_tick = 0
- Slot length is exactly DIV cycles; a full frame is 4*DIV cycles.
- Display update latency: from the load cycle to the first cycle showing the new value, the time until the next commit point plus 1 cycle. The worst case is 4*DIV + 1 cycles.
- Reset mid-frame: abandons any pending value. The first cycle after rst deasserts shows digit 0 of zero.
- rst has priority over load on the same cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant non-zero nibble of shown are blanked: an = 4'b1111 during their slot, and hex is still driven.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - Slot timing is unchanged.
- Not defined: all four digits are always lit.

## Structure
- Shared package holds:
  - the digit-count constant (4);
  - the active-low anode pattern constants (AN_D0 = 4'b1110 … AN_D3 = 4'b0111, AN_OFF = 4'b1111).
- One sub-module, scan_prescaler: parameter DIV, ports clk/rst, output slot_end. It contains the prescaler counter only.
- The digit counter, buffers and output registers live in hex_scan_driver.

## Test plan
All tests use DIV = 4.
- Reset: assert rst for 2 cycles, then release. Required:
  - an = 1110, hex = 0, ready = 1;
  - digit advances every 4 cycles: 0,1,2,3,0;
  - frame_tick pulses once per 16 cycles.
- Load mid-frame: load value = 16'h12AF during the digit-1 slot. Required:
  - ready = 0 until the digit 3→0 wrap;
  - the next frame shows hex = F, A, 2, 1 with an = 1110, 1101, 1011, 0111;
  - ready returns to 1 at the commit.
- Double load: load 16'h1111, then 16'h2222 in the same frame. Required: only 2222 is displayed, and 1111 never appears.
- Load on the commit cycle: load 16'hBEEF with pending 16'h0005 on the commit cycle. Required: the next frame shows 0005, the following frame shows BEEF, and ready stays 0 across the first commit.
- Leading-zero blanking, with LEADING_ZERO_BLANK_EN defined:
  - load 16'h00A0: digits 2 and 3 show an = 1111; digits 0 and 1 are lit;
  - load 16'h0000: only digit 0 is lit, with hex = 0.
- Reset mid-operation: assert rst with pending set during the digit-2 slot. Required: all registers are at their reset values, and the pending value is never displayed.
